rom_arbiter: RTL and testbench



---
 rtl/rom_arbiter.sv | 130 +++++++++++++
 tb/tb_rom_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// rom_arbiter
// Sequential ROM-read arbiter for the neural-net datapath. Walks every ROM
// address from 0 to 2**ADDR_WIDTH-1. Each word takes two steps: a FETCH
// cycle that strobes the ROM, then a WRITE cycle that steers the word into
// one node FIFO. The FIFOs are picked in round-robin order with a one-hot
// write enable. The sequence stalls while the FIFO fabric reports full.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous, active-high reset
//   full     - FIFO back-pressure; blocks fetches and writes while high
//   addr     - registered ROM read address
//   fetch_en - ROM read strobe (ROM data valid the following cycle)
//   wr_en    - one-hot FIFO write strobe, bit k selects node k
//   all_done - completion flag
//
// Optional feature (macro ROM_ARBITER_WRAP_EN):
//   When defined, the arbiter never parks in DONE. After the last address is
//   written it wraps to address 0, and all_done becomes a one-cycle pulse.
//   When undefined, DONE is terminal and all_done is sticky.

module rom_arbiter #(
  parameter int NUM_NODES  = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  full,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  fetch_en,
  output logic [NUM_NODES-1:0]  wr_en,
  output logic                  all_done
);

  localparam int PtrW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam logic [PtrW-1:0] LastNode = PtrW'(NUM_NODES - 1);

  // Reject configurations that make no sense before anything gets built.
  if (NUM_NODES < 1 || DATA_WIDTH < 1) begin : gBadParams
    $error("rom_arbiter: NUM_NODES and DATA_WIDTH must be >= 1");
  end

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [PtrW-1:0]       nodePtr_q, nodePtr_d;
  logic                  allDone_q, allDone_d;

  // Next-state logic and the combinational strobes. A high full freezes
  // every register and suppresses both strobes, so a stalled write is simply
  // retried on the first cycle full drops. The node pointer counts on its
  // own, so NUM_NODES does not have to divide the ROM depth. Both strobes
  // are also forced low while rst is high.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    nodePtr_d = nodePtr_q;
`ifdef ROM_ARBITER_WRAP_EN
    allDone_d = 1'b0;
`else
    allDone_d = allDone_q;
`endif
    fetch_en  = 1'b0;
    wr_en     = '0;

    case (state_q)
      FETCH: begin
        fetch_en = !full;
        if (!full) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (!full) begin
          wr_en     = NUM_NODES'(1) << nodePtr_q;
          nodePtr_d = (nodePtr_q == LastNode) ? '0 : nodePtr_q + 1'b1;
          if (addr_q == '1) begin
            allDone_d = 1'b1;
`ifdef ROM_ARBITER_WRAP_EN
            addr_d  = '0;
            state_d = FETCH;
`else
            state_d = DONE;
`endif
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    if (rst) begin
      fetch_en = 1'b0;
      wr_en    = '0;
    end
  end

  // State register. Reset puts the arbiter back at address 0 and node 0,
  // ready to fetch in the first cycle after rst falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      addr_q    <= '0;
      nodePtr_q <= '0;
      allDone_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      nodePtr_q <= nodePtr_d;
      allDone_q <= allDone_d;
    end
  end

  assign addr     = addr_q;
  assign all_done = allDone_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter
// Directed bench for rom_arbiter. It uses two instances:
//   dut  - default configuration (4 nodes, 4 ROM words)
//   dut3 - 3 nodes with 8 ROM words, so the node pointer is not aligned to the ROM depth
// Inputs change 1 time unit after a rising edge. Outputs are checked a
// little later in the same cycle, away from the edge.
// Building with ROM_ARBITER_WRAP_EN selects the wrap-mode expectations.

module tb_rom_arbiter;

  logic       clk = 1'b0;
  logic       rst, full;
  logic [1:0] addr;
  logic       fetch_en;
  logic [3:0] wr_en;
  logic       all_done;

  logic       rst3, full3;
  logic [2:0] addr3;
  logic       fetch_en3;
  logic [2:0] wr_en3;
  logic       all_done3;

  int checkCount = 0;
  int errorCount = 0;

  rom_arbiter #(.NUM_NODES(4), .ADDR_WIDTH(2), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .full(full), .addr(addr),
    .fetch_en(fetch_en), .wr_en(wr_en), .all_done(all_done)
  );

  rom_arbiter #(.NUM_NODES(3), .ADDR_WIDTH(3), .DATA_WIDTH(16)) dut3 (
    .clk(clk), .rst(rst3), .full(full3), .addr(addr3),
    .fetch_en(fetch_en3), .wr_en(wr_en3), .all_done(all_done3)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Move to just after the next rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Drive the back-pressure inputs, then let the combinational outputs settle.
  task automatic applyStimulus(input logic fullVal, input logic full3Val);
    full  = fullVal;
    full3 = full3Val;
    #1;
  endtask

  // Pulse reset on the default instance; it ends in the first active cycle.
  task automatic resetDut();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    logic [3:0] expWr;
    logic [2:0] expWr3;

    rst = 1'b1; rst3 = 1'b1; full = 1'b0; full3 = 1'b0;
    nextCycle();
    nextCycle();

    // Reset state, with both strobes held low while reset is asserted.
    checkOutput("rst_addr", 32'(addr), 32'd0);
    checkOutput("rst_fetch", 32'(fetch_en), 32'd0);
    checkOutput("rst_wr", 32'(wr_en), 32'd0);
    checkOutput("rst_done", 32'(all_done), 32'd0);

    // Full run with no back-pressure.
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("run_fetch_addr", 32'(addr), 32'(i));
      checkOutput("run_fetch_en", 32'(fetch_en), 32'd1);
      checkOutput("run_fetch_wr", 32'(wr_en), 32'd0);
      nextCycle();
      expWr = 4'b0001 << i;
      checkOutput("run_write_addr", 32'(addr), 32'(i));
      checkOutput("run_write_fetch", 32'(fetch_en), 32'd0);
      checkOutput("run_write_wr", 32'(wr_en), 32'(expWr));
      checkOutput("run_write_done", 32'(all_done), 32'd0);
      nextCycle();
    end
`ifdef ROM_ARBITER_WRAP_EN
    checkOutput("wrap_pulse", 32'(all_done), 32'd1);
    checkOutput("wrap_addr0", 32'(addr), 32'd0);
    checkOutput("wrap_fetch", 32'(fetch_en), 32'd1);
    nextCycle();
    checkOutput("wrap_wr", 32'(wr_en), 32'd1);
    for (int c = 1; c < 8; c++) begin
      checkOutput("wrap_no_pulse", 32'(all_done), 32'd0);
      nextCycle();
    end
    checkOutput("wrap_pulse2", 32'(all_done), 32'd1);
    checkOutput("wrap_addr0_2", 32'(addr), 32'd0);
`else
    // DONE ignores full and keeps all_done high.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(logic'(k % 2), 1'b0);
      checkOutput("done_flag", 32'(all_done), 32'd1);
      checkOutput("done_fetch", 32'(fetch_en), 32'd0);
      checkOutput("done_wr", 32'(wr_en), 32'd0);
      checkOutput("done_addr", 32'(addr), 32'd3);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0);
`endif

    // full held for 5 cycles while in FETCH at addr 1.
    resetDut();
    checkOutput("st_fetch0", 32'(fetch_en), 32'd1);
    nextCycle();
    checkOutput("st_wr0", 32'(wr_en), 32'd1);
    nextCycle();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("stall_fetch", 32'(fetch_en), 32'd0);
      checkOutput("stall_wr", 32'(wr_en), 32'd0);
      checkOutput("stall_addr", 32'(addr), 32'd1);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("resume_fetch", 32'(fetch_en), 32'd1);
    checkOutput("resume_addr", 32'(addr), 32'd1);
    nextCycle();
    checkOutput("resume_wr", 32'(wr_en), 32'd2);
    checkOutput("resume_waddr", 32'(addr), 32'd1);
    nextCycle();
    checkOutput("resume_addr2", 32'(addr), 32'd2);
    nextCycle();

    // full asserted in a WRITE cycle: the same write is retried afterwards.
    applyStimulus(1'b1, 1'b0);
    checkOutput("wstall_wr", 32'(wr_en), 32'd0);
    checkOutput("wstall_fetch", 32'(fetch_en), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0);
    checkOutput("wretry_wr", 32'(wr_en), 32'd4);
    checkOutput("wretry_addr", 32'(addr), 32'd2);
    nextCycle();
    checkOutput("wretry_next", 32'(addr), 32'd3);
    checkOutput("wretry_nfetch", 32'(fetch_en), 32'd1);

    // Asynchronous reset in the middle of the WRITE cycle for addr 2.
    resetDut();
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      nextCycle();
    end
    nextCycle();
    checkOutput("mid_wr2", 32'(wr_en), 32'd4);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_addr", 32'(addr), 32'd0);
    checkOutput("arst_wr", 32'(wr_en), 32'd0);
    checkOutput("arst_fetch", 32'(fetch_en), 32'd0);
    checkOutput("arst_done", 32'(all_done), 32'd0);
    nextCycle();
    rst = 1'b0;
    #1;
    checkOutput("restart_fetch", 32'(fetch_en), 32'd1);
    checkOutput("restart_addr", 32'(addr), 32'd0);
    nextCycle();
    checkOutput("restart_wr", 32'(wr_en), 32'd1);

    // Three nodes with eight words: wr_en cycles 001,010,100 across the run.
    rst3 = 1'b1;
    nextCycle();
    rst3 = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      checkOutput("n3_addr", 32'(addr3), 32'(i));
      checkOutput("n3_fetch", 32'(fetch_en3), 32'd1);
      nextCycle();
      expWr3 = 3'b001 << (i % 3);
      checkOutput("n3_wr", 32'(wr_en3), 32'(expWr3));
      checkOutput("n3_notdone", 32'(all_done3), 32'd0);
      nextCycle();
    end
    checkOutput("n3_done", 32'(all_done3), 32'd1);
    checkOutput("n3_done_wr", 32'(wr_en3), 32'd0);
`ifdef ROM_ARBITER_WRAP_EN
    checkOutput("n3_wrap_addr", 32'(addr3), 32'd0);
`else
    checkOutput("n3_done_addr", 32'(addr3), 32'd7);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
